blft_mem_ctrl: RTL and testbench
================================

# blft_mem_ctrl

Frame-memory controller that sits on the far side of the bilateral filter's pixel interface. It loads a 256x256 8-bit source image from a host stream into a source SRAM. It then answers the filter's read requests (`in_addr` → `in_data`/`in_valid`) and captures the filter's result writes (`out_valid`/`out_addr`/`out_data`) into a result SRAM. Once the filter raises `finish`, it streams the result frame back to the host.

## Interface
Parameters:
- `PIX_W`, 8, pixel width
- `ADDR_W`, 16, pixel address width ({row, col}); frame is 2^ADDR_W pixels

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `ld_valid`  in  1  host load pixel valid
- `ld_ready`  out  1  controller accepts load pixel
- `ld_data`  in  PIX_W  load pixel, raster order from address 0
- `in_addr`  in  ADDR_W  filter read address
- `in_valid`  out  1  `in_data` valid for current `in_addr`
- `in_data`  out  PIX_W  source pixel
- `out_valid`  in  1  filter write strobe
- `out_addr`  in  ADDR_W  filter write address
- `out_data`  in  PIX_W  filter result pixel
- `finish`  in  1  filter done (level)
- `src_cen`/`src_wen`  out  1  source SRAM chip/write enable, active high
- `src_a`  out  ADDR_W, `src_d`  out  PIX_W, `src_q`  in  PIX_W  source SRAM, read data 1 cycle after `src_cen`
- `dst_cen`/`dst_wen`/`dst_a`/`dst_d`/`dst_q`: result SRAM, same timing
- `rd_valid`  out  1, `rd_ready`  in  1, `rd_data`  out  PIX_W  host result stream, raster order
- `wr_cnt`  out  ADDR_W+1  distinct result writes captured
- `done`  out  1  drain complete, sticky

## Operation
- FSM: IDLE → LOAD → SERVE → DRAIN → DONE; every output is 0 while `rst`=0.
- IDLE: one cycle, clears `ld_cnt`, `wr_cnt`, `rd_cnt`, then enters LOAD.
- LOAD:
  - `ld_ready`=1.
  - On `ld_valid`&&`ld_ready`: src write at `ld_cnt` with `ld_data`, then `ld_cnt`++.
  - The accept at `ld_cnt`=2^ADDR_W−1 moves the FSM to SERVE. `ld_ready` is 0 in that next cycle.
- SERVE, two-phase loop:
  - REQ: `src_cen`=1, `src_a`=`in_addr`.
  - RSP: `in_valid`=1, `in_data`=`src_q`.
  - Result: `in_valid` pulses every other cycle, starting at the second SERVE cycle. `in_addr` only changes after a RSP cycle, so it is stable through REQ.
- Result writes (SERVE only):
  - Every cycle with `out_valid`=1: dst write `out_addr` ← `out_data`.
  - `wr_cnt`++ only when `out_addr` differs from the last written address, or on the first write. A held `out_valid` rewrites the same data and does not count.
  - Writes are independent of the REQ/RSP phase.
- `finish`=1 in SERVE: the same-cycle write still completes; next state is DRAIN; `in_valid` is forced 0 from then on.
- DRAIN:
  - Issue a dst read at `rd_cnt`; next cycle, `rd_valid`=1 with `rd_data`=`dst_q`, held in an output register until `rd_ready`.
  - On handshake: `rd_cnt`++ and issue the next read. Throughput is one pixel per 2 cycles with `rd_ready` tied high.
  - The handshake at `rd_cnt`=2^ADDR_W−1 moves the FSM to DONE.
- DONE: `done`=1; all strobes 0; the controller stays here until reset.
- `wr_cnt` saturates at 2^ADDR_W.
- Reset mid-operation: returns to IDLE, counters cleared; SRAM contents untouched.

## Timing
- Load: 1 pixel/cycle max, 2^ADDR_W accepts.
- Read latency: REQ cycle → `in_valid` next cycle (1 cycle). `in_data` is valid only while `in_valid`=1.
- Write latency: `out_valid` sampled → dst write in the same cycle (combinational `dst_*` from inputs, registered address compare).
- `finish` → first DRAIN read issue: 1 cycle. The first `rd_valid` follows 1 cycle later.
- `rd_valid` never drops without a handshake, and `rd_data` is stable while `rd_valid`&&!`rd_ready`.

## Configuration
- `BLFT_MEM_CLR_EN` defined:
  - Each LOAD accept also writes 0 to dst at `ld_cnt` (`dst_cen`=`dst_wen`=1).
  - Pixels the filter never writes drain as 0.
- Undefined: dst is untouched during LOAD, so unwritten pixels drain with prior contents.

## Test plan
- Load ramp (pixel = addr[7:0]), then filter model reads addr 0x0102 → `in_valid` high 1 cycle later with `in_data`=0x02; next read no earlier than 2 cycles after.
- `ld_valid` toggled 50%: exactly 65536 accepts, SERVE entered the cycle after the last accept, no `in_valid` during LOAD.
- `out_valid` held 4 cycles at addr 0x0505 data 0x7F, then addr 0x0506 data 0x80 → dst[0x0505]=0x7F, dst[0x0506]=0x80, `wr_cnt`=2.
- `finish` asserted with a same-cycle write to 0xFFFF data 0x11 → write lands, `in_valid` stays 0, drain of pixel 0xFFFF returns 0x11.
- Drain with `rd_ready` low 3 cycles on pixel 0 → `rd_valid`/`rd_data` held; after 65536 handshakes `done`=1. With `BLFT_MEM_CLR_EN`, unwritten pixels read 0x00.
- Reset (`rst`=0) mid-SERVE → next cycle all outputs 0; after release, IDLE then `ld_ready`=1, `wr_cnt`=0.

Source files
------------

// File: rtl/blft_mem_ctrl.sv
// blft_mem_ctrl: frame-memory controller for the bilateral filter (load, serve, capture, drain).
// Define BLFT_MEM_CLR_EN to zero the result SRAM while the source frame loads.
module blft_mem_ctrl #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [PIX_W-1:0]  ld_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              in_valid,
    output logic [PIX_W-1:0]  in_data,
    input  logic              out_valid,
    input  logic [ADDR_W-1:0] out_addr,
    input  logic [PIX_W-1:0]  out_data,
    input  logic              finish,
    output logic              src_cen,
    output logic              src_wen,
    output logic [ADDR_W-1:0] src_a,
    output logic [PIX_W-1:0]  src_d,
    input  logic [PIX_W-1:0]  src_q,
    output logic              dst_cen,
    output logic              dst_wen,
    output logic [ADDR_W-1:0] dst_a,
    output logic [PIX_W-1:0]  dst_d,
    input  logic [PIX_W-1:0]  dst_q,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD, SERVE, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ADDR_W:0]   FULL = {1'b1, {ADDR_W{1'b0}}};
    state_t            state;
    logic [ADDR_W-1:0] ld_cnt, rd_cnt, last_a;
    logic [ADDR_W:0]   wr_cnt_q;
    logic [PIX_W-1:0]  rd_q;
    logic              have_last, rsp, pend, hold;
    logic              ld_acc, serve, wr_new, hs;
    assign ld_acc = rst && state == LOAD && ld_valid;
    assign serve  = rst && state == SERVE;
    assign wr_new = serve && out_valid && (!have_last || out_addr != last_a);
    assign hs     = rst && state == DRAIN && (pend || hold) && rd_ready;
    // All SRAM strobes are combinational so writes land in the cycle they are presented.
    always_comb begin
        ld_ready = rst && state == LOAD;
        in_valid = serve && rsp && !finish;
        in_data  = in_valid ? src_q : '0;
        rd_valid = rst && state == DRAIN && (pend || hold);
        rd_data  = !rd_valid ? '0 : pend ? dst_q : rd_q;
        wr_cnt   = rst ? wr_cnt_q : '0;
        done     = rst && state == DONE;
        src_cen  = 1'b0;
        src_wen  = 1'b0;
        src_a    = '0;
        src_d    = '0;
        dst_cen  = 1'b0;
        dst_wen  = 1'b0;
        dst_a    = '0;
        dst_d    = '0;
        if (ld_acc) begin
            src_cen = 1'b1;
            src_wen = 1'b1;
            src_a   = ld_cnt;
            src_d   = ld_data;
`ifdef BLFT_MEM_CLR_EN
            dst_cen = 1'b1;
            dst_wen = 1'b1;
            dst_a   = ld_cnt;
`endif
        end
        if (serve && !rsp) begin
            src_cen = 1'b1;
            src_a   = in_addr;
        end
        if (serve && out_valid) begin
            dst_cen = 1'b1;
            dst_wen = 1'b1;
            dst_a   = out_addr;
            dst_d   = out_data;
        end
        if (rst && state == DRAIN && !pend && !hold) begin
            dst_cen = 1'b1;
            dst_a   = rd_cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ld_cnt    <= '0;
            rd_cnt    <= '0;
            wr_cnt_q  <= '0;
            last_a    <= '0;
            have_last <= 1'b0;
            rsp       <= 1'b0;
            pend      <= 1'b0;
            hold      <= 1'b0;
            rd_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ld_cnt    <= '0;
                    rd_cnt    <= '0;
                    wr_cnt_q  <= '0;
                    have_last <= 1'b0;
                    rsp       <= 1'b0;
                    state     <= LOAD;
                end
                LOAD: if (ld_valid) begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_cnt == LAST) state <= SERVE;
                end
                SERVE: begin
                    rsp <= !rsp;
                    if (out_valid) begin
                        last_a    <= out_addr;
                        have_last <= 1'b1;
                    end
                    if (wr_new && wr_cnt_q != FULL) wr_cnt_q <= wr_cnt_q + 1'b1;
                    if (finish) begin
                        state  <= DRAIN;
                        rd_cnt <= '0;
                        pend   <= 1'b0;
                        hold   <= 1'b0;
                    end
                end
                DRAIN: begin
                    // pend: read data arriving this cycle; hold: stalled pixel parked in rd_q
                    if (!pend && !hold) pend <= 1'b1;
                    else if (pend) begin
                        pend <= 1'b0;
                        if (!rd_ready) begin
                            hold <= 1'b1;
                            rd_q <= dst_q;
                        end
                    end else if (rd_ready) hold <= 1'b0;
                    if (hs) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST) state <= DONE;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blft_mem_ctrl.sv
// tb_blft_mem_ctrl: randomized directed bench for blft_mem_ctrl on a 4096-pixel frame.
module tb_blft_mem_ctrl;
    localparam int AW = 12, PW = 8, N = 1 << AW;
    logic clk = 0, rst = 0;
    logic ld_valid = 0, ld_ready, in_valid, out_valid = 0, finish = 0;
    logic [PW-1:0] ld_data = 0, in_data, out_data = 0, src_d, src_q, dst_d, dst_q, rd_data;
    logic [AW-1:0] in_addr = 0, out_addr = 0, src_a, dst_a;
    logic src_cen, src_wen, dst_cen, dst_wen, rd_valid, rd_ready = 0, done;
    logic [AW:0] wr_cnt;
    logic [PW-1:0] src_mem [N], dst_mem [N];
    logic [PW-1:0] src_ref [N], dst_ref [N], got [N];
    logic pre = 0;
    int errors = 0, checks = 0;
    int wexp, sc, cnt, cyc, idx, bad_rdy, bad_iv;
    logic have_w, pv;
    logic [AW-1:0] last_w, cur, oa, prev_oa;

    always #5 clk = ~clk;

    blft_mem_ctrl #(.PIX_W(PW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .in_addr(in_addr), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .finish(finish),
        .src_cen(src_cen), .src_wen(src_wen), .src_a(src_a), .src_d(src_d), .src_q(src_q),
        .dst_cen(dst_cen), .dst_wen(dst_wen), .dst_a(dst_a), .dst_d(dst_d), .dst_q(dst_q),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wr_cnt(wr_cnt), .done(done)
    );

    always @(posedge clk) begin
        if (src_cen) begin
            if (src_wen) src_mem[src_a] <= src_d;
            else src_q <= src_mem[src_a];
        end
        if (pre) for (int i = 0; i < N; i++) dst_mem[i] <= 8'(i) ^ 8'hA5;
        else if (dst_cen) begin
            if (dst_wen) dst_mem[dst_a] <= dst_d;
            else dst_q <= dst_mem[dst_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{ld_ready, in_valid, in_data, src_cen, src_wen, src_a, src_d, dst_cen, dst_wen,
                 dst_a, dst_d, rd_valid, rd_data, wr_cnt, done};
    endfunction

    // One SERVE cycle: in_valid is expected on every second cycle since SERVE entry.
    task automatic serve_cycle(input logic ov, input logic [AW-1:0] a, input logic [PW-1:0] d,
                               input logic fin, input logic [AW-1:0] ra);
        if (sc % 2 == 0) cur = ra;
        in_addr = cur; out_valid = ov; out_addr = a; out_data = d; finish = fin;
        #3;
        chk("in_valid", in_valid, (sc % 2 == 1) && !fin);
        if (sc % 2 == 1 && !fin) chk("in_data", in_data, src_ref[cur]);
        chk("wr_cnt", wr_cnt, wexp);
        chk("ld_ready_serve", ld_ready, 0);
        if (ov) begin
            dst_ref[a] = d;
            if (!have_w || a != last_w) wexp = (wexp < N) ? wexp + 1 : wexp;
            last_w = a;
            have_w = 1;
        end
        sc++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) dst_ref[i] = 8'(i) ^ 8'hA5;
        pre = 1;
        tick();
        pre = 0;
        tick();
        #3;
        chk("reset_outputs", any_out(), 0);
        tick();
        rst = 1;
        #3;
        chk("idle_ld_ready", ld_ready, 0);
        chk("idle_wr_cnt", wr_cnt, 0);
        tick();
        cnt = 0; cyc = 0; bad_rdy = 0; bad_iv = 0;
        while (cnt < N && cyc < 4 * N) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data = 8'(cnt);
            #3;
            if (!ld_ready) bad_rdy++;
            if (in_valid) bad_iv++;
            if (ld_valid && ld_ready) begin
                src_ref[cnt] = 8'(cnt);
`ifdef BLFT_MEM_CLR_EN
                dst_ref[cnt] = 8'h00;
`endif
                cnt++;
            end
            cyc++;
            tick();
        end
        ld_valid = 0;
        chk("load_accepts", cnt, N);
        chk("load_ld_ready_drop", bad_rdy, 0);
        chk("load_in_valid", bad_iv, 0);
        sc = 0; wexp = 0; have_w = 0; last_w = 0;
        serve_cycle(0, 0, 0, 0, 12'h102);
        serve_cycle(1, 12'h505, 8'h7F, 0, 0);
        chk("rd_0102_data", src_ref[12'h102], 8'h02);
        serve_cycle(1, 12'h505, 8'h7F, 0, 12'h0AA);
        serve_cycle(1, 12'h505, 8'h7F, 0, 0);
        serve_cycle(1, 12'h505, 8'h7F, 0, 12'h3C3);
        serve_cycle(1, 12'h506, 8'h80, 0, 0);
        chk("wr_cnt_two", wr_cnt, 2);
        prev_oa = 12'h100;
        for (int k = 0; k < 300; k++) begin
            oa = ($urandom_range(0, 3) == 0) ? prev_oa : 12'($urandom_range(0, 12'h4FF));
            serve_cycle($urandom_range(0, 2) != 0, oa, 8'($urandom), 0, 12'($urandom_range(0, N - 1)));
            prev_oa = oa;
        end
        if (sc % 2 == 1) serve_cycle(0, 0, 0, 0, 0);
        serve_cycle(1, 12'hFFF, 8'h11, 1, 0);
        out_valid = 0;
        #3;
        chk("drain_issue_in_valid", in_valid, 0);
        chk("drain_issue_rd_valid", rd_valid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            rd_ready = (k == 3);
            #3;
            chk("pix0_rd_valid", rd_valid, 1);
            chk("pix0_rd_data", rd_data, dst_ref[0]);
            chk("pix0_in_valid", in_valid, 0);
            got[0] = rd_data;
            tick();
        end
        idx = 1; cyc = 0; pv = 0;
        while (idx < N && cyc < 8 * N) begin
            rd_ready = $urandom_range(0, 3) != 0;
            #3;
            if (pv) chk("rd_valid_held", rd_valid, 1);
            if (rd_valid) begin
                chk("rd_data", rd_data, dst_ref[idx]);
                got[idx] = rd_data;
                if (rd_ready) idx++;
            end
            pv = rd_valid && !rd_ready;
            cyc++;
            tick();
        end
        rd_ready = 0;
        chk("drain_count", idx, N);
        #3;
        chk("done", done, 1);
        chk("done_rd_valid", rd_valid, 0);
        chk("done_in_valid", in_valid, 0);
        chk("got_0505", got[12'h505], 8'h7F);
        chk("got_0506", got[12'h506], 8'h80);
        chk("got_0FFF", got[12'hFFF], 8'h11);
`ifdef BLFT_MEM_CLR_EN
        chk("got_unwritten", got[12'h800], 8'h00);
`else
        chk("got_unwritten", got[12'h800], 8'hA5);
`endif
        tick();
        finish = 0;
        rst = 0;
        tick();
        rst = 1;
        #3;
        chk("rerun_idle_ld_ready", ld_ready, 0);
        tick();
        for (int i = 0; i < N; i++) begin
            ld_valid = 1; ld_data = 8'(i ^ 7);
            if (i == 0) begin
                #3;
                chk("rerun_load_ld_ready", ld_ready, 1);
            end
            src_ref[i] = 8'(i ^ 7);
            tick();
        end
        ld_valid = 0;
        sc = 0; wexp = 0; have_w = 0;
        serve_cycle(1, 12'h010, 8'h33, 0, 12'h005);
        serve_cycle(1, 12'h011, 8'h34, 0, 0);
        serve_cycle(1, 12'h012, 8'h35, 0, 12'h006);
        rst = 0;
        out_valid = 1;
        tick();
        #3;
        chk("rst_mid_outputs", any_out(), 0);
        tick();
        rst = 1;
        out_valid = 0;
        #3;
        chk("rst_idle_ld_ready", ld_ready, 0);
        chk("rst_idle_wr_cnt", wr_cnt, 0);
        tick();
        #3;
        chk("rst_load_ld_ready", ld_ready, 1);
        chk("rst_load_wr_cnt", wr_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
